// File: rtl/next_pc_unit.sv
// rtl/next_pc_unit.sv - fetch PC register, branch/jump resolution and return-address stack
module next_pc_unit #(
  parameter int          WIDTH      = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC    = 32'h0000_4180,
  parameter int          DELAY_SLOT = 1,
  parameter int          RAS_DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             stall,
  input  logic [2:0]                       branch_op,
  input  logic [1:0]                       cmp,
  input  logic [2:0]                       jump_op,
  input  logic [WIDTH-1:0]                 br_pc,
  input  logic [15:0]                      imm16,
  input  logic [25:0]                      index26,
  input  logic [WIDTH-1:0]                 jr_target,
  input  logic                             exc_req,
  input  logic                             eret_req,
  input  logic [WIDTH-1:0]                 epc,
  output logic [WIDTH-1:0]                 pc,
  output logic [WIDTH-1:0]                 next_pc,
  output logic                             flush_slot,
  output logic [WIDTH-1:0]                 ras_top,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic                             ras_miss
);

  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [WIDTH-1:0] PC_RST  = WIDTH'(RESET_PC);
  localparam logic [WIDTH-1:0] PC_EXC  = WIDTH'(EXC_VEC);

  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] br_seq;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] j_target;
  logic [WIDTH-1:0] link_addr;
  logic             taken;
  logic             jump_j;
  logic             jump_r;
  logic             redirect;
  logic             ras_upd;

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    top_ptr;
  logic [PW-1:0]    ptr_inc;
  logic [PW-1:0]    ptr_dec;
  logic             ras_empty;
  logic             ras_full;

  assign pc_plus4  = pc + WIDTH'(4);
  assign br_seq    = br_pc + WIDTH'(4);
  assign br_target = br_seq + {{(WIDTH-18){imm16[15]}}, imm16, 2'b00};
  assign j_target  = {br_seq[WIDTH-1:28], index26, 2'b00};
  assign link_addr = br_pc + WIDTH'(8);

  assign jump_j = (jump_op == 3'b100) || (jump_op == 3'b101);
  assign jump_r = (jump_op == 3'b110) || (jump_op == 3'b111);

  // cmp=11 is an invalid compare and must never take a branch
  always_comb begin
    taken = 1'b0;
    if (cmp != 2'b11) begin
      case (branch_op)
        3'b001:  taken = (cmp == 2'b01);
        3'b010:  taken = (cmp != 2'b01);
        3'b011:  taken = (cmp != 2'b00);
        3'b100:  taken = (cmp == 2'b10);
        3'b101:  taken = (cmp != 2'b10);
        3'b110:  taken = (cmp == 2'b00);
        default: taken = 1'b0;
      endcase
    end
  end

  always_comb begin
    next_pc  = pc_plus4;
    redirect = 1'b0;
    if (exc_req) begin
      next_pc = PC_EXC;
    end else if (eret_req) begin
      next_pc = epc;
    end else if (stall) begin
      next_pc = pc;
    end else if (taken) begin
      next_pc  = br_target;
      redirect = 1'b1;
    end else if (jump_j) begin
      next_pc  = j_target;
      redirect = 1'b1;
    end else if (jump_r) begin
      next_pc  = jr_target;
      redirect = 1'b1;
    end
  end

  assign flush_slot = (DELAY_SLOT == 0) ? redirect : 1'b0;

  assign ras_upd   = !exc_req && !eret_req && !stall && (jump_j || jump_r);
  assign ras_empty = (ras_count == '0);
  assign ras_full  = (ras_count == CW'(RAS_DEPTH));
  assign ptr_inc   = (top_ptr == PW'(RAS_DEPTH - 1)) ? '0 : top_ptr + PW'(1);
  assign ptr_dec   = (top_ptr == '0) ? PW'(RAS_DEPTH - 1) : top_ptr - PW'(1);
  assign ras_top   = ras_empty ? '0 : ras_mem[top_ptr];

  // entries carry no reset; validity is tracked by ras_count alone
  always_ff @(posedge clk) begin
    if (ras_upd && (jump_op == 3'b101)) begin
      ras_mem[ptr_inc] <= link_addr;
    end else if (ras_upd && (jump_op == 3'b111)) begin
      ras_mem[top_ptr] <= link_addr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc        <= PC_RST;
      top_ptr   <= '0;
      ras_count <= '0;
      ras_miss  <= 1'b0;
    end else begin
      pc       <= next_pc;
      ras_miss <= 1'b0;
      if (exc_req) begin
        top_ptr   <= '0;
        ras_count <= '0;
      end else if (ras_upd) begin
        case (jump_op)
          3'b101: begin
            // a full stack wraps onto its oldest entry
            top_ptr <= ptr_inc;
            if (!ras_full) ras_count <= ras_count + CW'(1);
          end
          3'b110: begin
            if (ras_empty) begin
              ras_miss <= 1'b1;
            end else begin
              ras_miss  <= (jr_target != ras_mem[top_ptr]);
              top_ptr   <= ptr_dec;
              ras_count <= ras_count - CW'(1);
            end
          end
          3'b111: begin
            if (ras_empty) begin
              ras_miss  <= 1'b1;
              ras_count <= CW'(1);
            end else begin
              ras_miss <= (jr_target != ras_mem[top_ptr]);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_next_pc_unit.sv
// tb/tb_next_pc_unit.sv - self-checking bench for next_pc_unit with a queue-based reference model
module tb_next_pc_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        stall = 1'b0;
  logic        exc_req = 1'b0;
  logic        eret_req = 1'b0;
  logic [2:0]  branch_op = '0;
  logic [2:0]  jump_op = '0;
  logic [1:0]  cmp = '0;
  logic [31:0] br_pc = '0;
  logic [31:0] jr_target = '0;
  logic [31:0] epc = '0;
  logic [15:0] imm16 = '0;
  logic [25:0] index26 = '0;

  logic [31:0] pc0, next0, top0, pc1, next1, top1;
  logic [2:0]  cnt0, cnt1;
  logic        flush0, flush1, miss0, miss1;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  logic [31:0] mpc = 32'h0000_3000;
  logic [31:0] mq[$];
  bit          mmiss = 1'b0;

  always #5 clk = ~clk;

  next_pc_unit #(.DELAY_SLOT(1)) u_ds1 (
    .clk(clk), .reset_n(reset_n), .stall(stall), .branch_op(branch_op), .cmp(cmp),
    .jump_op(jump_op), .br_pc(br_pc), .imm16(imm16), .index26(index26),
    .jr_target(jr_target), .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
    .pc(pc1), .next_pc(next1), .flush_slot(flush1), .ras_top(top1),
    .ras_count(cnt1), .ras_miss(miss1)
  );

  next_pc_unit #(.DELAY_SLOT(0)) u_ds0 (
    .clk(clk), .reset_n(reset_n), .stall(stall), .branch_op(branch_op), .cmp(cmp),
    .jump_op(jump_op), .br_pc(br_pc), .imm16(imm16), .index26(index26),
    .jr_target(jr_target), .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
    .pc(pc0), .next_pc(next0), .flush_slot(flush0), .ras_top(top0),
    .ras_count(cnt0), .ras_miss(miss0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // which priority rule (1..7) governs the next PC for the current inputs
  function automatic int m_rule();
    bit lt, eq, gt, tk;
    lt = (cmp == 2'd0);
    eq = (cmp == 2'd1);
    gt = (cmp == 2'd2);
    case (branch_op)
      3'd1:    tk = eq;
      3'd2:    tk = lt || gt;
      3'd3:    tk = eq || gt;
      3'd4:    tk = gt;
      3'd5:    tk = lt || eq;
      3'd6:    tk = lt;
      default: tk = 1'b0;
    endcase
    if (exc_req) return 1;
    if (eret_req) return 2;
    if (stall) return 3;
    if (tk) return 4;
    if (jump_op == 3'd4 || jump_op == 3'd5) return 5;
    if (jump_op == 3'd6 || jump_op == 3'd7) return 6;
    return 7;
  endfunction

  function automatic logic [31:0] m_next();
    case (m_rule())
      1:       return 32'h0000_4180;
      2:       return epc;
      3:       return mpc;
      4:       return br_pc + 32'd4 + 32'(int'($signed(imm16)) * 4);
      5:       return ((br_pc + 32'd4) & 32'hF000_0000) + 32'(index26) * 32'd4;
      6:       return jr_target;
      default: return mpc + 32'd4;
    endcase
  endfunction

  initial forever begin : model
    int r;
    logic [31:0] nx;
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      mpc = 32'h0000_3000;
      mq.delete();
      mmiss = 1'b0;
    end else begin
      r = m_rule();
      nx = m_next();
      mmiss = 1'b0;
      if (r == 1) begin
        mq.delete();
      end else if (r >= 4 && jump_op >= 3'd4) begin
        case (jump_op)
          3'd5: begin
            if (mq.size() == 4) void'(mq.pop_front());
            mq.push_back(br_pc + 32'd8);
          end
          3'd6: begin
            if (mq.size() == 0) mmiss = 1'b1;
            else begin
              mmiss = (jr_target != mq[$]);
              void'(mq.pop_back());
            end
          end
          3'd7: begin
            if (mq.size() == 0) begin
              mmiss = 1'b1;
              mq.push_back(br_pc + 32'd8);
            end else begin
              mmiss = (jr_target != mq[$]);
              mq[$] = br_pc + 32'd8;
            end
          end
          default: ;
        endcase
      end
      mpc = nx;
    end
  end

  initial forever begin : compare
    logic [31:0] etop;
    int r;
    @(negedge clk);
    if (chk_en) begin
      etop = (mq.size() != 0) ? mq[$] : 32'h0;
      r = m_rule();
      chk("pc", pc1, mpc);
      chk("pc_ds0", pc0, mpc);
      chk("next_pc", next1, m_next());
      chk("next_pc_ds0", next0, m_next());
      chk("flush_ds1", {31'b0, flush1}, 32'h0);
      chk("flush_ds0", {31'b0, flush0}, {31'b0, (r >= 4 && r <= 6)});
      chk("ras_top", top1, etop);
      chk("ras_top_ds0", top0, etop);
      chk("ras_count", 32'(cnt1), 32'(mq.size()));
      chk("ras_count_ds0", 32'(cnt0), 32'(mq.size()));
      chk("ras_miss", {31'b0, miss1}, {31'b0, mmiss});
      chk("ras_miss_ds0", {31'b0, miss0}, {31'b0, mmiss});
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; exc_req = 0; eret_req = 0;
    branch_op = 3'd0; jump_op = 3'd0; cmp = 2'd0;
  endtask

  task automatic set_br(input logic [2:0] op, input logic [1:0] c, input logic [31:0] bpc,
                        input logic [15:0] imm);
    idle();
    branch_op = op; cmp = c; br_pc = bpc; imm16 = imm;
  endtask

  task automatic set_j(input logic [2:0] op, input logic [31:0] bpc, input logic [31:0] tgt);
    idle();
    jump_op = op; br_pc = bpc; jr_target = tgt;
  endtask

  initial begin
    #1 reset_n = 0;
    #10;
    reset_n = 1;
    chk_en = 1;
    chk("rst_pc", pc1, 32'h3000);
    chk("rst_count", 32'(cnt1), 32'h0);
    chk("rst_top", top1, 32'h0);
    chk("rst_miss", {31'b0, miss1}, 32'h0);
    tick(); chk("seq_pc1", pc1, 32'h3004);
    tick(); chk("seq_pc2", pc1, 32'h3008);
    tick(); chk("seq_pc3", pc1, 32'h300C);
    #2 reset_n = 0;
    #1 chk("async_rst_pc", pc1, 32'h3000);
    tick();
    reset_n = 1;

    set_br(3'b001, 2'b01, 32'h3010, 16'hFFFC);
    #1 chk("beq_taken_next", next1, 32'h3004);
    chk("beq_flush_ds0", {31'b0, flush0}, 32'h1);
    chk("beq_flush_ds1", {31'b0, flush1}, 32'h0);
    tick(); chk("beq_pc", pc1, 32'h3004);
    cmp = 2'b10;
    #1 chk("beq_nt_next", next1, 32'h3008);
    tick();
    set_br(3'b011, 2'b11, 32'h3010, 16'hFFFC);
    #1 chk("bgez_invalid_next", next1, 32'h300C);
    tick();
    set_br(3'b010, 2'b01, 32'h3010, 16'h0008);
    #1 chk("bne_nt_flush_ds0", {31'b0, flush0}, 32'h0);
    tick();
    set_j(3'b100, 32'h3010, 32'h0);
    index26 = 26'h123;
    #1 chk("j_next", next1, 32'h0000_048C);
    chk("j_flush_ds0", {31'b0, flush0}, 32'h1);
    chk("j_flush_ds1", {31'b0, flush1}, 32'h0);
    tick(); chk("j_pc", pc1, 32'h0000_048C);
    set_br(3'b111, 2'b01, 32'h3010, 16'h0004);
    jump_op = 3'b011;
    tick();

    for (int i = 0; i < 5; i++) begin
      set_j(3'b101, 32'h3000 + 32'(i) * 32'h100, 32'h0);
      tick();
    end
    chk("jal5_count", 32'(cnt1), 32'd4);
    chk("jal5_top", top1, 32'h3408);
    for (int i = 0; i < 4; i++) begin
      set_j(3'b110, 32'h2000, 32'h3408 - 32'(i) * 32'h100);
      tick();
      chk("jr_hit_miss", {31'b0, miss1}, 32'h0);
    end
    set_j(3'b110, 32'h2000, 32'h1000);
    tick();
    chk("jr_empty_miss", {31'b0, miss1}, 32'h1);
    chk("jr_empty_count", 32'(cnt1), 32'h0);
    idle(); tick();
    chk("jr_miss_pulse_end", {31'b0, miss1}, 32'h0);

    set_j(3'b101, 32'h5000, 32'h0); tick();
    set_j(3'b101, 32'h5100, 32'h0); tick();
    set_j(3'b111, 32'h6000, 32'h1234); tick();
    chk("jalr_miss", {31'b0, miss1}, 32'h1);
    chk("jalr_count", 32'(cnt1), 32'd2);
    chk("jalr_top", top1, 32'h6008);
    idle(); tick();
    chk("jalr_pulse_end", {31'b0, miss1}, 32'h0);

    set_j(3'b101, 32'h7000, 32'h0);
    stall = 1;
    tick();
    set_j(3'b110, 32'h7000, 32'hDEAD);
    stall = 1;
    tick();
    chk("stall_no_miss", {31'b0, miss1}, 32'h0);

    set_br(3'b001, 2'b01, 32'h3010, 16'hFFFC);
    exc_req = 1; stall = 1;
    #1 chk("exc_next", next1, 32'h4180);
    chk("exc_flush_ds0", {31'b0, flush0}, 32'h0);
    tick();
    chk("exc_pc", pc1, 32'h4180);
    chk("exc_count", 32'(cnt1), 32'h0);
    set_j(3'b101, 32'h7000, 32'h0); tick();
    idle();
    eret_req = 1; stall = 1; epc = 32'h3200;
    tick();
    chk("eret_pc", pc1, 32'h3200);
    chk("eret_count", 32'(cnt1), 32'h1);

    set_br(3'b100, 2'b10, 32'h8000, 16'h0010);
    jump_op = 3'b101;
    tick();
    chk("br_over_jal_pc", pc1, 32'h8044);
    set_br(3'b001, 2'b01, 32'hFFFF_FFF0, 16'h0004);
    tick();
    chk("wrap_pc", pc1, 32'h0000_0004);

    idle(); exc_req = 1; tick();
    set_j(3'b111, 32'h9000, 32'h4444); tick();
    chk("jalr_empty_miss", {31'b0, miss1}, 32'h1);
    chk("jalr_empty_count", 32'(cnt1), 32'h1);
    chk("jalr_empty_top", top1, 32'h9008);
    idle(); tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
